// File: rtl/fluorescence_pkg.sv
// Shared constants, FSM state type and byte helper for the lock-in result UART link.
package fluorescence_pkg;

  localparam logic [7:0] SYNC_BYTE_0 = 8'hA5;
  localparam logic [7:0] SYNC_BYTE_1 = 8'h5A;

  localparam int FRAME_BYTES = 20;

  // Byte positions inside a frame.
  localparam logic [4:0] SEQ_BYTE        = 5'd2;
  localparam logic [4:0] FIRST_WORD_BYTE = 5'd3;
  localparam logic [4:0] CHECKSUM_BYTE   = 5'(FRAME_BYTES - 1);

  // Result word indices, in transmit order.
  localparam int RESULT_WORDS          = 4;
  localparam int WORD_IN_PHASE         = 0;
  localparam int WORD_QUADRATURE       = 1;
  localparam int WORD_IN_PHASE_COUNT   = 2;
  localparam int WORD_QUADRATURE_COUNT = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BYTE = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Big-endian byte pick: pos 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] pos);
    logic [7:0] b;
    case (pos)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lockin_result_uart_tx_if.sv
// Result strobe/words from the lock-in counter plus UART link status and FSM debug state.
interface lockin_result_uart_tx_if;

  logic                      result_valid;
  logic [31:0]               in_phase_value;
  logic [31:0]               quadrature_value;
  logic [31:0]               in_phase_count;
  logic [31:0]               quadrature_count;
  logic                      uart_tx_pin;
  logic                      busy;
  logic [7:0]                frame_sequence;
  logic [7:0]                dropped_frames;
  fluorescence_pkg::state_t  state;

  modport master (
    output result_valid, in_phase_value, quadrature_value, in_phase_count, quadrature_count,
    input  uart_tx_pin, busy, frame_sequence, dropped_frames, state
  );

  modport slave (
    input  result_valid, in_phase_value, quadrature_value, in_phase_count, quadrature_count,
    output uart_tx_pin, busy, frame_sequence, dropped_frames, state
  );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: baud counter plus 10-bit shift register, LSB first, line idles high.
// Handshake: a byte is taken on any rising edge where byte_valid and byte_ready are both 1;
// byte_ready is also raised during the final stop-bit clock so a waiting byte starts exactly
// when the previous stop bit ends, giving back-to-back bytes with no idle gap.
module uart_byte_tx #(
  parameter int BAUD_DIVISOR = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIVISOR - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic          bit_end;
  logic          last_clk;
  logic          take;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign last_clk   = active && bit_end && (bit_cnt == 4'd9);
  assign byte_ready = !active || last_clk;
  assign take       = byte_valid && byte_ready;
  assign tx         = shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shift    <= '1;
    end else if (take) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shift    <= {1'b1, byte_data, 1'b0};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        shift    <= {1'b1, shift[9:1]};
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          bit_cnt <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lockin_result_uart_tx.sv
// Snapshots lock-in I/Q results on a strobe and streams them as a 20-byte framed UART packet.
module lockin_result_uart_tx
  import fluorescence_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int BAUD_DIVISOR    = CLOCK_FREQUENCY / BAUD_RATE
) (
  input  logic                     clock_50_mhz,
  input  logic                     reset_n,
  lockin_result_uart_tx_if.slave   bus
);

  state_t      state;
  state_t      state_next;
  logic [31:0] words [RESULT_WORDS];
  logic [7:0]  seq_snap;
  logic [7:0]  checksum;
  logic [7:0]  frame_seq_q;
  logic [7:0]  dropped_q;
  logic [4:0]  byte_index;
  logic [4:0]  byte_sel;
  logic [3:0]  word_pos;
  logic [7:0]  tx_byte;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        accept;
  logic        drop;
  logic        take;

  assign busy   = (state != IDLE);
  assign accept = bus.result_valid && !busy;
  assign drop   = bus.result_valid && busy;
  assign take   = byte_valid && byte_ready;

  // LOAD hands byte 0 to the idle serializer so its start bit begins one edge after accept;
  // WAIT_BYTE hands the next byte during the final stop-bit clock of the current one.
  always_comb begin
    state_next = state;
    byte_valid = 1'b0;
    byte_sel   = 5'd0;
    case (state)
      IDLE: begin
        if (bus.result_valid) state_next = LOAD;
      end
      LOAD: begin
        byte_valid = 1'b1;
        byte_sel   = 5'd0;
        if (byte_ready) state_next = SEND;
      end
      SEND: begin
        state_next = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (byte_ready) begin
          if (byte_index < CHECKSUM_BYTE) begin
            byte_valid = 1'b1;
            byte_sel   = byte_index + 5'd1;
            state_next = SEND;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  assign word_pos = 4'(byte_sel - FIRST_WORD_BYTE);

  always_comb begin
    tx_byte = 8'h00;
    if (byte_sel == 5'd0)               tx_byte = SYNC_BYTE_0;
    else if (byte_sel == 5'd1)          tx_byte = SYNC_BYTE_1;
    else if (byte_sel == SEQ_BYTE)      tx_byte = seq_snap;
    else if (byte_sel == CHECKSUM_BYTE) tx_byte = ~checksum + 8'd1;
    else                                tx_byte = word_byte(words[word_pos[3:2]], word_pos[1:0]);
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < RESULT_WORDS; k++) words[k] <= '0;
      seq_snap   <= 8'd0;
      checksum   <= 8'd0;
      byte_index <= 5'd0;
    end else if (accept) begin
      words[WORD_IN_PHASE]         <= bus.in_phase_value;
      words[WORD_QUADRATURE]       <= bus.quadrature_value;
      words[WORD_IN_PHASE_COUNT]   <= bus.in_phase_count;
      words[WORD_QUADRATURE_COUNT] <= bus.quadrature_count;
      seq_snap   <= frame_seq_q;
      checksum   <= 8'd0;
      byte_index <= 5'd0;
    end else if (take) begin
      byte_index <= byte_sel;
      // Running sum of the checksummed bytes, one byte per hand-off.
      if (byte_sel >= SEQ_BYTE && byte_sel < CHECKSUM_BYTE) checksum <= checksum + tx_byte;
    end
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_seq_q <= 8'd0;
      dropped_q   <= 8'd0;
    end else begin
      if (state == DONE) frame_seq_q <= frame_seq_q + 8'd1;
      if (drop && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
    end
  end

  uart_byte_tx #(
    .BAUD_DIVISOR (BAUD_DIVISOR)
  ) u_byte_tx (
    .clk        (clock_50_mhz),
    .rst_n      (reset_n),
    .byte_valid (byte_valid),
    .byte_data  (tx_byte),
    .byte_ready (byte_ready),
    .tx         (bus.uart_tx_pin)
  );

  assign bus.busy           = busy;
  assign bus.frame_sequence = frame_seq_q;
  assign bus.dropped_frames = dropped_q;
  assign bus.state          = state;

endmodule

// File: tb/tb_lockin_result_uart_tx.sv
// Bench for lockin_result_uart_tx: UART receiver feeding a byte scoreboard, vector table, corner sequences.
module tb_lockin_result_uart_tx;
  import fluorescence_pkg::*;

  localparam int DIV        = 4;
  localparam int DIV_W      = 1;
  localparam int FRAME_CLKS = FRAME_BYTES * 10 * DIV;

  // clock / reset
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rst_w_n = 1'b0;
  always #5 clk = ~clk;

  lockin_result_uart_tx_if bus ();
  lockin_result_uart_tx_if bus_w ();

  lockin_result_uart_tx #(.BAUD_DIVISOR(DIV)) dut (
    .clock_50_mhz (clk),
    .reset_n      (rst_n),
    .bus          (bus)
  );

  // Fast-baud instance used only to walk frame_sequence through its wrap.
  lockin_result_uart_tx #(.BAUD_DIVISOR(DIV_W)) dut_w (
    .clock_50_mhz (clk),
    .reset_n      (rst_w_n),
    .bus          (bus_w)
  );

  // scoreboard state
  int         n_vec     = 0;
  int         n_fail    = 0;
  logic [7:0] exp_q[$];
  int         rx_epoch  = 0;
  int         rx_count  = 0;
  logic [7:0] last_byte = 8'h00;
  logic       wrap_done = 1'b0;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
    logic [31:0] ic;
    logic [31:0] qc;
    logic [7:0]  exp_seq;
    logic [7:0]  exp_chk;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic push_frame(input logic [7:0] seq, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    logic [7:0]  b[20];
    logic [31:0] w[4];
    logic [7:0]  sum;
    w    = '{w0, w1, w2, w3};
    b[0] = 8'hA5;
    b[1] = 8'h5A;
    b[2] = seq;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        b[3 + 4 * k + j] = w[k][31 - 8 * j -: 8];
    sum = 8'h00;
    for (int k = 2; k < 19; k++) sum = sum + b[k];
    b[19] = 8'h00 - sum;
    for (int k = 0; k < 20; k++) exp_q.push_back(b[k]);
  endtask

  // driver tasks (called at a negedge, return at the following negedge)
  task automatic strobe(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d);
    bus.in_phase_value   = a;
    bus.quadrature_value = b;
    bus.in_phase_count   = c;
    bus.quadrature_count = d;
    bus.result_valid     = 1'b1;
    @(negedge clk);
    bus.result_valid     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: busy still %b after %0d clks, required 0", name, bus.busy, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_epoch++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // UART receiver: samples mid-bit on negedges and feeds the scoreboard.
  initial begin : uart_rx
    forever begin
      @(negedge clk);
      if (bus.uart_tx_pin === 1'b0) begin : one_byte
        int         ep;
        logic       start_bit;
        logic       stop_bit;
        logic [7:0] data;
        ep = rx_epoch;
        repeat (DIV / 2) @(negedge clk);
        start_bit = bus.uart_tx_pin;
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          data[b] = bus.uart_tx_pin;
        end
        repeat (DIV) @(negedge clk);
        stop_bit = bus.uart_tx_pin;
        if (ep == rx_epoch) begin
          rx_count++;
          last_byte = data;
          check("rx_start_bit", {31'd0, start_bit}, 32'd0);
          check("rx_stop_bit", {31'd0, stop_bit}, 32'd1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rx_unexpected_byte: got %0h, required no byte", data);
          end else begin
            check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // frame_sequence wrap on the fast instance, each frame strobed on the first idle cycle
  initial begin : wrap_run
    int n;
    bus_w.result_valid     = 1'b0;
    bus_w.in_phase_value   = '0;
    bus_w.quadrature_value = '0;
    bus_w.in_phase_count   = '0;
    bus_w.quadrature_count = '0;
    repeat (3) @(negedge clk);
    rst_w_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 257; k++) begin
      n = 0;
      while (bus_w.busy !== 1'b0 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) begin
        n_vec++;
        n_fail++;
        $display("FAIL wrap_timeout: busy %b at frame %0d, required 0", bus_w.busy, k);
        break;
      end
      if (k == 0 || k == 1 || k == 128 || k == 255 || k == 256)
        check("wrap_seq", {24'd0, bus_w.frame_sequence}, 32'(k % 256));
      bus_w.in_phase_value   = $urandom;
      bus_w.quadrature_value = $urandom;
      bus_w.result_valid     = 1'b1;
      @(negedge clk);
      bus_w.result_valid     = 1'b0;
      if (k == 255) check("wrap_accept", {31'd0, bus_w.busy}, 32'd1);
    end
    n = 0;
    while (bus_w.busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wrap_final_seq", {24'd0, bus_w.frame_sequence}, 32'd1);
    wrap_done = 1'b1;
  end

  initial begin : main
    int bad;
    int cnt;
    vecs[0] = '{32'hFFFF_FFFB, 32'd7,          32'd100,      32'd3,         8'd0, 8'h9A};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000,  32'h0000_0000, 32'h0000_0000, 8'd1, 8'hFF};
    vecs[2] = '{32'h0102_0304, 32'h0000_0000,  32'h0000_0000, 32'h0000_0000, 8'd2, 8'hF4};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd3, 8'h0D};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF,  32'h0000_00FF, 32'h1234_5678, 8'd4, 8'hED};

    bus.result_valid     = 1'b0;
    bus.in_phase_value   = '0;
    bus.quadrature_value = '0;
    bus.in_phase_count   = '0;
    bus.quadrature_count = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_line", {31'd0, bus.uart_tx_pin}, 32'd1);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_seq", {24'd0, bus.frame_sequence}, 32'd0);
    check("reset_dropped", {24'd0, bus.dropped_frames}, 32'd0);
    check("reset_state", 32'(bus.state), 32'(IDLE));

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.uart_tx_pin !== 1'b1 || bus.busy !== 1'b0 || bus.frame_sequence !== 8'd0 ||
          bus.dropped_frames !== 8'd0) bad++;
    end
    check("idle_1000_bad_cycles", bad, 0);

    // vector table: one frame per entry, strobed on the first idle cycle
    for (int v = 0; v < 5; v++) begin
      wait_idle("table_idle", 5000);
      push_frame(vecs[v].exp_seq, vecs[v].i, vecs[v].q, vecs[v].ic, vecs[v].qc);
      strobe(vecs[v].i, vecs[v].q, vecs[v].ic, vecs[v].qc);
      check("accept_busy", {31'd0, bus.busy}, 32'd1);
      check("load_line_high", {31'd0, bus.uart_tx_pin}, 32'd1);
      @(negedge clk);
      check("start_bit_latency", {31'd0, bus.uart_tx_pin}, 32'd0);
      cnt = 2;
      while (bus.busy === 1'b1 && cnt < 5000) begin
        @(negedge clk);
        if (bus.busy === 1'b1) cnt++;
      end
      check("busy_clks", cnt, FRAME_CLKS + 2);
      repeat (2) @(negedge clk);
      check("table_drained", exp_q.size(), 0);
      check("table_seq_after", {24'd0, bus.frame_sequence}, {24'd0, vecs[v].exp_seq + 8'd1});
      check("table_chk", {24'd0, last_byte}, {24'd0, vecs[v].exp_chk});
    end

    // strobe while busy is dropped, in-flight frame untouched
    do_reset();
    push_frame(8'd0, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
    strobe(32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
    repeat (98) @(negedge clk);
    strobe(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    check("drop_count", {24'd0, bus.dropped_frames}, 32'd1);
    check("drop_still_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle("drop_idle", 5000);
    repeat (2) @(negedge clk);
    check("drop_drained", exp_q.size(), 0);
    check("drop_seq", {24'd0, bus.frame_sequence}, 32'd1);
    push_frame(8'd1, 32'hCAFE_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004);
    strobe(32'hCAFE_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004);
    wait_idle("third_idle", 5000);
    repeat (2) @(negedge clk);
    check("third_drained", exp_q.size(), 0);
    check("third_seq", {24'd0, bus.frame_sequence}, 32'd2);
    check("third_dropped", {24'd0, bus.dropped_frames}, 32'd1);

    // 300 strobes during one frame: dropped_frames saturates
    do_reset();
    push_frame(8'd0, 32'h0BAD_F00D, 32'hFFFF_FF00, 32'd5000, 32'd4999);
    strobe(32'h0BAD_F00D, 32'hFFFF_FF00, 32'd5000, 32'd4999);
    for (int i = 0; i < 300; i++) begin
      strobe($urandom, $urandom, $urandom, $urandom);
      @(negedge clk);
      if (i == 199) check("dropped_200", {24'd0, bus.dropped_frames}, 32'd200);
    end
    check("dropped_saturated", {24'd0, bus.dropped_frames}, 32'd255);
    wait_idle("sat_idle", 5000);
    repeat (2) @(negedge clk);
    check("sat_drained", exp_q.size(), 0);
    check("sat_dropped_hold", {24'd0, bus.dropped_frames}, 32'd255);

    // asynchronous reset in the middle of byte 7 (a 0x00 byte, so the line is low)
    do_reset();
    push_frame(8'd0, 32'h1234_5678, 32'h00AB_CDEF, 32'd1, 32'd2);
    strobe(32'h1234_5678, 32'h00AB_CDEF, 32'd1, 32'd2);
    repeat (1 + 7 * 10 * DIV + 20) @(negedge clk);
    check("pre_reset_line", {31'd0, bus.uart_tx_pin}, 32'd0);
    #2;
    rst_n = 1'b0;
    rx_epoch++;
    exp_q.delete();
    #1;
    check("async_reset_line", {31'd0, bus.uart_tx_pin}, 32'd1);
    check("async_reset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_reset_line", {31'd0, bus.uart_tx_pin}, 32'd1);
    check("post_reset_seq", {24'd0, bus.frame_sequence}, 32'd0);
    push_frame(8'd0, 32'h0000_0001, 32'h8000_0001, 32'd77, 32'd88);
    strobe(32'h0000_0001, 32'h8000_0001, 32'd77, 32'd88);
    wait_idle("post_reset_idle", 5000);
    repeat (2) @(negedge clk);
    check("post_reset_drained", exp_q.size(), 0);
    check("post_reset_seq_after", {24'd0, bus.frame_sequence}, 32'd1);

    cnt = 0;
    while (!wrap_done && cnt < 100000) begin
      @(negedge clk);
      cnt++;
    end
    if (!wrap_done) begin
      n_vec++;
      n_fail++;
      $display("FAIL wrap_done: got 0 after %0d clks, required 1", cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
